pipe_ctrl_n: RTL and testbench



---
 rtl/pipe_ctrl_n.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl_n.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_n.sv
// Pipeline control for the in-order core: per-stage stall/bubble/flush, redirect PC, refill hold, hang watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl_n #(
    parameter int unsigned NUM_STAGES  = 7,
    parameter int unsigned PC_WD       = 64,
    parameter int unsigned REFILL_CYC  = 1,
    parameter int unsigned STALL_LIMIT = 1024,
    parameter int unsigned CNT_WD      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_STAGES-1:0]         stallreq,
    input  logic [NUM_STAGES-1:0]         flushreq,
    input  logic [NUM_STAGES*PC_WD-1:0]   flush_pc,
    output logic [NUM_STAGES-1:0]         stall,
    output logic [NUM_STAGES-1:0]         bubble,
    output logic [NUM_STAGES-1:0]         flush,
    output logic [PC_WD-1:0]              new_pc,
    output logic                          redirect_valid,
    output logic                          hang,
    output logic [CNT_WD-1:0]             stall_cycles,
    output logic [CNT_WD-1:0]             flush_count
);

    localparam int unsigned RUN_WD = $clog2(STALL_LIMIT + 1);
    localparam int unsigned RCNT_WD = 4;

    typedef enum logic [1:0] {
        IDLE,
        REDIR,
        REFILL
    } state_t;

    state_t                  state;
    logic [RCNT_WD-1:0]      refill_cnt;
    logic [RUN_WD-1:0]       stall_run;
    logic [RUN_WD-1:0]       run_nxt;
    logic [NUM_STAGES-1:0]   raw_stall;
    logic [PC_WD-1:0]        sel_pc;
    logic                    any_flush;
    logic                    any_stallreq;
    logic                    flush_acc;
    logic                    stall_acc;

    // Scan from the oldest stage down: oldest flusher wins and kills everything younger.
    always_comb begin
        flush     = '0;
        raw_stall = '0;
        stall     = '0;
        bubble    = '0;
        sel_pc    = '0;
        flush_acc = 1'b0;
        stall_acc = 1'b0;
        for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
            flush[i] = flush_acc;
            if (flushreq[i] && !flush_acc) begin
                sel_pc = flush_pc[i*PC_WD +: PC_WD];
            end
            flush_acc    = flush_acc | flushreq[i];
            stall_acc    = stall_acc | stallreq[i];
            raw_stall[i] = stall_acc;
        end
        if (state == REFILL) begin
            raw_stall[0] = 1'b1;
        end
        stall = raw_stall & ~flush;
        for (int i = 1; i < int'(NUM_STAGES); i++) begin
            bubble[i] = stall[i-1] & ~stall[i] & ~flush[i];
        end
    end

    assign any_flush    = |flushreq;
    assign any_stallreq = |stallreq;

    // Consecutive-stall run length, saturating at the hang threshold.
    always_comb begin
        run_nxt = stall_run;
        if (any_flush || !any_stallreq) begin
            run_nxt = '0;
        end else if (stall_run != RUN_WD'(STALL_LIMIT)) begin
            run_nxt = stall_run + RUN_WD'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            refill_cnt     <= '0;
            new_pc         <= '0;
            redirect_valid <= 1'b0;
            stall_run      <= '0;
            hang           <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            stall_run      <= run_nxt;
            if (run_nxt == RUN_WD'(STALL_LIMIT)) begin
                hang <= 1'b1;
            end
            // A new flush always restarts the redirect, even mid-refill.
            if (any_flush) begin
                state          <= REDIR;
                new_pc         <= sel_pc;
                redirect_valid <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    REDIR: begin
                        if (REFILL_CYC == 0) begin
                            state <= IDLE;
                        end else begin
                            state      <= REFILL;
                            refill_cnt <= RCNT_WD'(REFILL_CYC);
                        end
                    end
                    REFILL: begin
                        if (refill_cnt <= RCNT_WD'(1)) begin
                            state <= IDLE;
                        end else begin
                            refill_cnt <= refill_cnt - RCNT_WD'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    // Saturating event counters; they hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((|stall) && (stall_cycles != {CNT_WD{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_WD'(1);
            end
            if (any_flush && (flush_count != {CNT_WD{1'b1}})) begin
                flush_count <= flush_count + CNT_WD'(1);
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed bench for pipe_ctrl_n: stall/bubble/flush vectors, redirect timing, refill restart, reset abort, watchdog.
module tb_pipe_ctrl_n;

    localparam int unsigned NS = 7;
    localparam int unsigned PW = 64;
    localparam int unsigned CW = 32;

    typedef struct packed {
        logic [NS-1:0] s;
        logic [NS-1:0] b;
        logic [NS-1:0] f;
    } comb_t;

    logic              clk;
    logic              rst;
    logic [NS-1:0]     stallreq;
    logic [NS-1:0]     flushreq;
    logic [NS*PW-1:0]  flush_pc;
    logic [NS-1:0]     stall;
    logic [NS-1:0]     bubble;
    logic [NS-1:0]     flush;
    logic [PW-1:0]     new_pc;
    logic              redirect_valid;
    logic              hang;
    logic [CW-1:0]     stall_cycles;
    logic [CW-1:0]     flush_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] q_pc[$];
    comb_t       q_comb[$];
    logic [63:0] exp_pc;

    pipe_ctrl_n #(
        .NUM_STAGES (NS),
        .PC_WD      (PW),
        .REFILL_CYC (1),
        .STALL_LIMIT(4),
        .CNT_WD     (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq      (stallreq),
        .flushreq      (flushreq),
        .flush_pc      (flush_pc),
        .stall         (stall),
        .bubble        (bubble),
        .flush         (flush),
        .new_pc        (new_pc),
        .redirect_valid(redirect_valid),
        .hang          (hang),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input int k, input logic [63:0] v);
        flush_pc[k*PW +: PW] = v;
    endtask

    // Drive one cycle of requests and compare the combinational vectors at the falling edge.
    task automatic step(input string tag, input logic [NS-1:0] s, input logic [NS-1:0] f,
                        input logic [NS-1:0] es, input logic [NS-1:0] eb, input logic [NS-1:0] ef);
        comb_t c;
        stallreq = s;
        flushreq = f;
        q_comb.push_back({es, eb, ef});
        @(negedge clk);
        c = q_comb.pop_front();
        check({tag, "_stall"},  64'(stall),  64'(c.s));
        check({tag, "_bubble"}, 64'(bubble), 64'(c.b));
        check({tag, "_flush"},  64'(flush),  64'(c.f));
    endtask

    // Every redirect pulse must match the next expected target; a stray or stretched pulse finds an empty queue.
    always @(negedge clk) begin
        if (redirect_valid === 1'b1) begin
            if (q_pc.size() == 0) begin
                check("redirect_unexpected", 64'(redirect_valid), 64'(0));
            end else begin
                exp_pc = q_pc.pop_front();
                check("redirect_pc", 64'(new_pc), exp_pc);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        stallreq = '0;
        flushreq = '0;
        flush_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_stall",  64'(stall),  64'(0));
        check("rst_bubble", 64'(bubble), 64'(0));
        check("rst_flush",  64'(flush),  64'(0));
        check("rst_new_pc", 64'(new_pc), 64'(0));
        check("rst_redir",  64'(redirect_valid), 64'(0));
        check("rst_hang",   64'(hang), 64'(0));
        check("rst_stall_cycles", 64'(stall_cycles), 64'(0));
        check("rst_flush_count",  64'(flush_count),  64'(0));
        rst = 1'b0;
        tick();

        // Stall from stage 2 freezes 0..2 and bubbles stage 3.
        for (int i = 0; i < 3; i++) begin
            step("stall3", 7'b0000100, 7'b0, 7'b0000111, 7'b0001000, 7'b0);
            tick();
        end
        step("stall_release", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        check("hang_after_3", 64'(hang), 64'(0));
        tick();

        // Single flush from EX: redirect at T+1, stage 0 held at T+2, idle at T+3.
        set_pc(3, 64'h8000_0040);
        set_pc(5, 64'hdead_beef);
        q_pc.push_back(64'h8000_0040);
        step("flush_ex", 7'b0, 7'b0001000, 7'b0, 7'b0, 7'b0000111);
        check("flush_ex_no_redir_yet", 64'(redirect_valid), 64'(0));
        tick();
        step("redir_t1", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        check("redir_t1_valid", 64'(redirect_valid), 64'(1));
        check("redir_t1_pc", 64'(new_pc), 64'h8000_0040);
        tick();
        step("refill_t2", 7'b0, 7'b0, 7'b0000001, 7'b0000010, 7'b0);
        check("refill_t2_valid", 64'(redirect_valid), 64'(0));
        tick();
        step("idle_t3", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        tick();

        // Two flushers: oldest (stage 5) wins.
        set_pc(5, 64'h100);
        set_pc(3, 64'h200);
        q_pc.push_back(64'h100);
        step("flush_two", 7'b0, 7'b0101000, 7'b0, 7'b0, 7'b0011111);
        tick();
        step("flush_two_redir", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        check("flush_two_pc", 64'(new_pc), 64'h100);
        tick();
        step("flush_two_refill", 7'b0, 7'b0, 7'b0000001, 7'b0000010, 7'b0);
        tick();
        step("flush_two_idle", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        tick();

        // Stall and flush together, then a newer flush during refill restarts it.
        set_pc(3, 64'h40);
        q_pc.push_back(64'h40);
        step("stall_flush", 7'b0010000, 7'b0001000, 7'b0011000, 7'b0100000, 7'b0000111);
        tick();
        step("sf_redir", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        tick();
        set_pc(2, 64'h300);
        q_pc.push_back(64'h300);
        step("flush_in_refill", 7'b0, 7'b0000100, 7'b0, 7'b0, 7'b0000011);
        tick();
        step("refire_redir", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        check("refire_valid", 64'(redirect_valid), 64'(1));
        check("refire_pc", 64'(new_pc), 64'h300);
        tick();
        step("refire_refill", 7'b0, 7'b0, 7'b0000001, 7'b0000010, 7'b0);
        tick();
        step("refire_idle", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        tick();

        // Reset while in REDIR aborts the refill and clears the redirect.
        set_pc(6, 64'h500);
        q_pc.push_back(64'h500);
        step("flush_wb", 7'b0, 7'b1000000, 7'b0, 7'b0, 7'b0111111);
        tick();
        stallreq = '0;
        flushreq = '0;
        rst      = 1'b1;
        @(negedge clk);
        check("wb_redir_valid", 64'(redirect_valid), 64'(1));
        tick();
        @(negedge clk);
        check("abort_stall",  64'(stall),  64'(0));
        check("abort_bubble", 64'(bubble), 64'(0));
        check("abort_new_pc", 64'(new_pc), 64'(0));
        check("abort_redir",  64'(redirect_valid), 64'(0));
        rst = 1'b0;
        tick();
        step("abort_no_refill", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        tick();

        // A flush restarts the stall run, so 3+3 stalled cycles do not trip the watchdog.
        for (int i = 0; i < 3; i++) begin
            step("wd_pre", 7'b0000100, 7'b0, 7'b0000111, 7'b0001000, 7'b0);
            check("wd_pre_hang", 64'(hang), 64'(0));
            tick();
        end
        set_pc(3, 64'h600);
        q_pc.push_back(64'h600);
        step("wd_flush", 7'b0000100, 7'b0001000, 7'b0, 7'b0, 7'b0000111);
        tick();
        for (int i = 0; i < 3; i++) begin
            step("wd_post", 7'b0000100, 7'b0, 7'b0000111, 7'b0001000, 7'b0);
            check("wd_post_hang", 64'(hang), 64'(0));
            tick();
        end
        step("wd_drop", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        check("wd_drop_hang", 64'(hang), 64'(0));
`ifdef PIPE_CTRL_PERF_CNT_EN
        check("wd_stall_cycles", 64'(stall_cycles), 64'(6));
        check("wd_flush_count",  64'(flush_count),  64'(1));
`else
        check("wd_stall_cycles", 64'(stall_cycles), 64'(0));
        check("wd_flush_count",  64'(flush_count),  64'(0));
`endif
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Four consecutive stall cycles set the sticky hang flag.
        for (int i = 0; i < 4; i++) begin
            step("hang_run", 7'b0000100, 7'b0, 7'b0000111, 7'b0001000, 7'b0);
            check("hang_before_limit", 64'(hang), 64'(0));
            tick();
        end
        step("hang_drop", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        check("hang_set", 64'(hang), 64'(1));
`ifdef PIPE_CTRL_PERF_CNT_EN
        check("hang_stall_cycles", 64'(stall_cycles), 64'(4));
`else
        check("hang_stall_cycles", 64'(stall_cycles), 64'(0));
`endif
        check("hang_flush_count", 64'(flush_count), 64'(0));
        tick();
        step("hang_idle", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
        check("hang_sticky", 64'(hang), 64'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("hang_cleared_by_rst", 64'(hang), 64'(0));

        check("redirect_queue_empty", 64'(q_pc.size()), 64'(0));
        check("comb_queue_empty", 64'(q_comb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
